ts_access_arbiter: RTL and testbench

//   Controls the single port of the 16x16 time-surface memory and shares it between three requesters:
//     - decoded-event timestamp writes, buffered in a small queue;
//     - feature-extractor scan reads;
//     - a whole-grid clear sweep.

---
 rtl/ts_access_arbiter.sv | 171 +++++++++++++++++
 tb/tb_ts_access_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_access_arbiter.sv
// Single-port access arbiter for the time-surface memory: queued event writes,
// scan reads with starvation protection, and a full-grid clear sweep.
module ts_access_arbiter #(
   parameter int unsigned ADDR_BITS    = 8,
   parameter int unsigned TS_BITS      = 16,
   parameter int unsigned EVQ_DEPTH    = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ev_valid,
   output logic                 ev_ready,
   input  logic [3:0]           ev_x,
   input  logic [3:0]           ev_y,
   input  logic [TS_BITS-1:0]   ev_ts,
   input  logic                 rd_req,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic                 rd_gnt,
   output logic [TS_BITS-1:0]   rd_data,
   output logic                 rd_data_valid,
   input  logic                 clear_start,
   output logic                 clear_busy,
   output logic                 mem_wr_en,
   output logic                 mem_rd_en,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [TS_BITS-1:0]   mem_wr_ts,
   input  logic [TS_BITS-1:0]   mem_rd_ts
);

   localparam int unsigned PtrBits    = (EVQ_DEPTH > 1) ? $clog2(EVQ_DEPTH) : 1;
   localparam int unsigned CntBits    = PtrBits + 1;
   localparam int unsigned StarveBits = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [0:0] {StArb, StClear} state_e;

   state_e                 state_q;
   logic [ADDR_BITS:0]     sweep_q;
   logic [ADDR_BITS:0]     sweep_d;
   logic [StarveBits-1:0]  starve_q;
   logic [PtrBits-1:0]     wr_ptr_q;
   logic [PtrBits-1:0]     rd_ptr_q;
   logic [CntBits-1:0]     count_q;
   logic [CntBits-1:0]     count_d;
   logic                   ev_ready_q;
   logic                   rd_data_valid_q;

   logic [ADDR_BITS-1:0]   q_addr [EVQ_DEPTH];
   logic [TS_BITS-1:0]     q_ts   [EVQ_DEPTH];

   logic [ADDR_BITS-1:0]   ev_addr;
   logic                   push;
   logic                   pop;
   logic                   do_read;
   logic                   do_write;
   logic                   starved;
   logic                   q_empty;

   assign ev_addr = ADDR_BITS'({ev_y, ev_x});
   assign q_empty = (count_q == '0);
   assign starved = (starve_q == StarveBits'(STARVE_LIMIT));
   assign push    = rst_n && ev_valid && ev_ready_q;
   assign sweep_d = sweep_q + 1'b1;

   // Grant decode; all access strobes are suppressed while reset is asserted.
   always_comb begin
      do_read   = 1'b0;
      do_write  = 1'b0;
      pop       = 1'b0;
      mem_addr  = '0;
      mem_wr_ts = '0;
      if (rst_n) begin
         unique case (state_q)
            StArb: begin
               if (!clear_start) begin
                  if (rd_req && starved) begin
                     do_read = 1'b1;
                  end else if (!q_empty) begin
                     do_write = 1'b1;
                     pop      = 1'b1;
                  end else if (rd_req) begin
                     do_read = 1'b1;
                  end
               end
            end
            StClear: do_write = 1'b1;
            default: ;
         endcase
      end
      if (do_read) begin
         mem_addr = rd_addr;
      end else if (pop) begin
         mem_addr  = q_addr[rd_ptr_q];
         mem_wr_ts = q_ts[rd_ptr_q];
      end else if (do_write) begin
         mem_addr = sweep_q[ADDR_BITS-1:0];
      end
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // Queue storage needs no reset: entries are only read below count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         q_addr[wr_ptr_q] <= ev_addr;
         q_ts[wr_ptr_q]   <= ev_ts;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= StArb;
         sweep_q         <= '0;
         starve_q        <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         ev_ready_q      <= 1'b1;
         rd_data_valid_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q         <= count_d;
         ev_ready_q      <= (count_d != CntBits'(EVQ_DEPTH));
         rd_data_valid_q <= do_read;

         unique case (state_q)
            StArb: begin
               if (rd_req && !do_read) begin
                  if (!starved) begin
                     starve_q <= starve_q + 1'b1;
                  end
               end else begin
                  starve_q <= '0;
               end
               if (clear_start) begin
                  state_q <= StClear;
                  sweep_q <= '0;
               end
            end
            StClear: begin
               sweep_q <= sweep_d;
               if (sweep_d[ADDR_BITS]) begin
                  state_q <= StArb;
               end
            end
            default: state_q <= StArb;
         endcase
      end
   end

   assign ev_ready      = ev_ready_q;
   assign rd_gnt        = do_read;
   assign mem_rd_en     = do_read;
   assign mem_wr_en     = do_write;
   assign clear_busy    = (state_q == StClear);
   assign rd_data_valid = rd_data_valid_q;
   // The memory output is already a register, so it is passed through in the valid cycle.
   assign rd_data       = rd_data_valid_q ? mem_rd_ts : '0;

endmodule

// File: tb/tb_ts_access_arbiter.sv
// Self-checking bench for ts_access_arbiter: directed tables and sequences plus a
// randomized run compared against a queue-based behavioural reference.
module tb_ts_access_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ev_valid;
   logic        ev_ready;
   logic [3:0]  ev_x;
   logic [3:0]  ev_y;
   logic [15:0] ev_ts;
   logic        rd_req;
   logic [7:0]  rd_addr;
   logic        rd_gnt;
   logic [15:0] rd_data;
   logic        rd_data_valid;
   logic        clear_start;
   logic        clear_busy;
   logic        mem_wr_en;
   logic        mem_rd_en;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wr_ts;
   logic [15:0] mem_rd_ts;

   always #5 clk = ~clk;

   ts_access_arbiter #(
      .ADDR_BITS(8), .TS_BITS(16), .EVQ_DEPTH(4), .STARVE_LIMIT(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_x(ev_x), .ev_y(ev_y), .ev_ts(ev_ts), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
      .clear_start(clear_start), .clear_busy(clear_busy), .mem_wr_en(mem_wr_en),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_wr_ts(mem_wr_ts),
      .mem_rd_ts(mem_rd_ts)
   );

   // Memory model: one port, registered read.
   logic [15:0] mem [256];
   bit          mem_init = 1'b1;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 | 16'(i);
         mem_rd_ts <= '0;
      end else begin
         if (mem_wr_en) mem[mem_addr] <= mem_wr_ts;
         if (mem_rd_en) mem_rd_ts <= mem[mem_addr];
      end
   end

   // Reference model state
   typedef struct packed {logic [7:0] addr; logic [15:0] ts;} ev_t;
   ev_t         m_q[$];
   bit          m_known, m_ready, m_clr, m_rdv;
   int          m_idx, m_starve;
   logic [15:0] m_rdata;
   logic [15:0] gold [256];

   int n_checks = 0;
   int n_fail   = 0;

   // Outputs sampled mid-cycle
   logic        s_ev_ready, s_gnt, s_rd, s_wr, s_busy, s_rdv;
   logic [7:0]  s_addr;
   logic [15:0] s_wts, s_rdata;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: sample and compare at negedge, advance model at posedge.
   task automatic cycle();
      bit          e_wr, e_rd, was_clr, push;
      logic [7:0]  e_addr;
      logic [15:0] e_ts;
      @(negedge clk);
      s_ev_ready = ev_ready; s_gnt = rd_gnt; s_rd = mem_rd_en; s_wr = mem_wr_en;
      s_busy = clear_busy; s_rdv = rd_data_valid; s_addr = mem_addr; s_wts = mem_wr_ts;
      s_rdata = rd_data;
      e_wr = 0; e_rd = 0; e_addr = '0; e_ts = '0;
      if (rst_n) begin
         if (m_clr) begin
            e_wr = 1; e_addr = 8'(m_idx);
         end else if (!clear_start) begin
            if (rd_req && m_starve == 8) begin
               e_rd = 1; e_addr = rd_addr;
            end else if (m_q.size() > 0) begin
               e_wr = 1; e_addr = m_q[0].addr; e_ts = m_q[0].ts;
            end else if (rd_req) begin
               e_rd = 1; e_addr = rd_addr;
            end
         end
      end
      if (m_known) begin
         check("outputs", {s_ev_ready, s_gnt, s_rd, s_wr, s_busy, s_rdv, s_addr, s_wts},
               {m_ready, e_rd, e_rd, e_wr, m_clr, m_rdv, e_addr, e_ts});
         if (m_rdv) check("rd_data", s_rdata, m_rdata);
      end
      @(posedge clk);
      if (!rst_n) begin
         m_q.delete(); m_ready = 1; m_clr = 0; m_starve = 0; m_rdv = 0; m_known = 1;
      end else begin
         push    = ev_valid && m_ready;
         was_clr = m_clr;
         m_rdv   = e_rd;
         if (e_rd) m_rdata = gold[rd_addr];
         if (e_wr) gold[e_addr] = e_ts;
         if (e_wr && !was_clr) void'(m_q.pop_front());
         if (push) m_q.push_back({ev_y, ev_x, ev_ts});
         m_ready = (m_q.size() != 4);
         if (!was_clr) m_starve = (rd_req && !e_rd) ? ((m_starve < 8) ? m_starve + 1 : 8) : 0;
         if (was_clr) begin
            m_idx++;
            if (m_idx == 256) m_clr = 0;
         end else if (clear_start) begin
            m_clr = 1; m_idx = 0;
         end
      end
      #1;
   endtask

   typedef struct {
      logic [3:0]  x;
      logic [3:0]  y;
      logic [15:0] ts;
      logic [7:0]  exp_addr;
      logic [15:0] exp_ts;
   } vec_t;
   vec_t vecs [5];

   initial begin
      int k, busy, gnts, errs;
      bit found;
      vecs[0] = '{4'd3,  4'd5,  16'h1234, 8'h53, 16'h1234};
      vecs[1] = '{4'd0,  4'd0,  16'h0001, 8'h00, 16'h0001};
      vecs[2] = '{4'd15, 4'd15, 16'hFFFF, 8'hFF, 16'hFFFF};
      vecs[3] = '{4'd10, 4'd2,  16'hBEEF, 8'h2A, 16'hBEEF};
      vecs[4] = '{4'd7,  4'd12, 16'h8000, 8'hC7, 16'h8000};
      for (int i = 0; i < 256; i++) gold[i] = 16'hA000 | 16'(i);
      m_known = 0; m_ready = 0; m_clr = 0; m_rdv = 0; m_idx = 0; m_starve = 0; m_rdata = '0;

      // Reset held 3 cycles with an event offered
      rst_n = 0; ev_valid = 1; ev_x = 4'd1; ev_y = 4'd1; ev_ts = 16'h5555;
      rd_req = 0; rd_addr = '0; clear_start = 0;
      cycle();
      mem_init = 0;
      for (int i = 0; i < 2; i++) begin
         cycle();
         check("reset_outputs_zero",
               {s_gnt, s_rd, s_wr, s_busy, s_rdv, s_addr, s_wts, s_rdata}, '0);
      end
      rst_n = 1; ev_valid = 0;
      cycle();
      check("ev_ready_after_reset", s_ev_ready, 1);
      check("no_strobe_after_reset", {s_wr, s_rd}, 0);

      // Single events into an empty queue
      foreach (vecs[i]) begin
         ev_valid = 1; ev_x = vecs[i].x; ev_y = vecs[i].y; ev_ts = vecs[i].ts;
         cycle();
         ev_valid = 0;
         cycle();
         check("event_wr_en", s_wr, 1);
         check("event_addr", s_addr, vecs[i].exp_addr);
         check("event_ts", s_wts, vecs[i].exp_ts);
      end

      // Starvation: continuous events, read held at 0x10
      ev_valid = 1; ev_x = 0; ev_y = 4'd3; ev_ts = 16'h3000;
      cycle();
      rd_req = 1; rd_addr = 8'h10; k = 0; found = 0;
      for (int i = 1; i <= 20 && !found; i++) begin
         ev_x = 4'(i); ev_ts = 16'h3000 + 16'(i);
         cycle();
         if (s_gnt) begin
            found = 1; k = i;
         end
      end
      check("starve_grant_cycle", k, 9);
      rd_req = 0; ev_valid = 0;
      cycle();
      check("starve_rd_valid", s_rdv, 1);
      check("starve_rd_data", s_rdata, 16'hA010);
      for (int i = 0; i < 6; i++) cycle();

      // Reset in the middle of a sweep
      clear_start = 1;
      cycle();
      clear_start = 0; found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         cycle();
         if (s_busy && s_addr == 8'h7F) found = 1;
      end
      check("sweep_reached_7f", found, 1);
      rst_n = 0;
      cycle();
      check("rst_sweep_no_write", s_wr, 0);
      rst_n = 1;
      cycle();
      check("rst_sweep_busy_low", s_busy, 0);
      check("rst_sweep_7f_cleared", mem[8'h7F], 16'h0000);
      check("rst_sweep_80_kept", mem[8'h80], 16'hA080);
      clear_start = 1;
      cycle();
      clear_start = 0;
      cycle();
      check("sweep_restart_addr", {s_busy, s_wr, s_addr}, {1'b1, 1'b1, 8'h00});
      for (int i = 0; i < 300 && s_busy; i++) cycle();

      // Full sweep with a read waiting
      rd_req = 1; rd_addr = 8'h22; clear_start = 1;
      cycle();
      check("clear_start_no_access", {s_gnt, s_wr}, 0);
      clear_start = 0; busy = 0; gnts = 0; errs = 0; found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         cycle();
         if (!s_busy) begin
            found = 1;
         end else begin
            if (s_gnt) gnts++;
            if (!s_wr || s_addr != 8'(busy) || s_wts != 0) errs++;
            busy++;
         end
      end
      check("sweep_length", busy, 256);
      check("sweep_no_read_grant", gnts, 0);
      check("sweep_addr_sequence", errs, 0);
      check("read_after_sweep", s_gnt, 1);
      rd_req = 0;
      cycle();
      check("read_after_sweep_data", {s_rdv, s_rdata}, {1'b1, 16'h0000});

      // Queue fills while the sweep stalls pops
      clear_start = 1;
      cycle();
      clear_start = 0;
      for (int i = 0; i < 4; i++) begin
         ev_valid = 1; ev_x = 4'(i); ev_y = 4'd9; ev_ts = 16'h7000 + 16'(i);
         cycle();
      end
      ev_x = 4'd4; ev_ts = 16'h7004;
      cycle();
      check("queue_full_not_ready", s_ev_ready, 0);
      found = 0;
      for (int i = 0; i < 300 && !found; i++) begin
         cycle();
         if (s_ev_ready) found = 1;
      end
      check("fifth_accepted", found, 1);
      check("fifth_after_sweep", s_busy, 0);
      ev_valid = 0; found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         cycle();
         if (s_wr && s_addr == 8'h94) found = 1;
      end
      check("fifth_written", found, 1);
      check("fifth_ts", s_wts, 16'h7004);

      // Randomized traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         rst_n       = ($urandom_range(0, 499) != 0);
         clear_start = ($urandom_range(0, 299) == 0);
         ev_valid    = ($urandom_range(0, 9) < 6);
         ev_x        = 4'($urandom); ev_y = 4'($urandom); ev_ts = 16'($urandom);
         cycle();
         if (rd_req && s_gnt) rd_req = 0;
         if (!rd_req && $urandom_range(0, 3) == 0) begin
            rd_req = 1; rd_addr = 8'($urandom);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
